// File: rtl/cache_rd_arbiter_pkg.sv
// Shared cache-refill definitions: FSM states, AXI read constants, line-bus width.
// No logic; imported by the arbiter, its line assembler and the AXI read interface users.
// CACHE_LINE_BUS matches the WayBus line width used by the cache data arrays.
`ifndef CACHE_RD_ARBITER_PKG_SV
`define CACHE_RD_ARBITER_PKG_SV

`define CACHE_LINE_BUS(words) [32*(words)-1:0]

package cache_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    localparam logic [3:0] ARID_IC        = 4'd0;
    localparam logic [3:0] ARID_DC        = 4'd1;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic logic [3:0] owner_arid(input owner_e owner);
        return (owner == OWN_DC) ? ARID_DC : ARID_IC;
    endfunction

endpackage

`endif

// File: rtl/cache_rd_arbiter_if.sv
// Cache-side AXI read channel (AR + R); master = arbiter, slave = AXI bridge.
// Pure wiring, no latency.
// Standard valid/ready on both AR and R.
interface cache_rd_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/cache_rd_arbiter_line_assembler.sv
// Beat counter plus line buffer: each write lands in word cnt, cnt wraps modulo LINE_WORDS.
// Write visible on line_o the cycle after we_i; clear has priority over write.
// No backpressure; the caller gates we_i with the R handshake.
module cache_line_assembler
    import cache_rd_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             we_i,
    input  logic [31:0]                      wdata_i,
    output logic `CACHE_LINE_BUS(LINE_WORDS) line_o
);
    localparam int CNT_W = $clog2(LINE_WORDS);

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LINE_WORDS-1:0][31:0]  line_q, line_d;

    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clr_i) begin
            cnt_d  = '0;
            line_d = '0;
        end else if (we_i) begin
            line_d[cnt_q] = wdata_i;
            // Power-of-two depth: natural overflow gives the modulo wrap.
            cnt_d         = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line_o = line_q;
endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read channel between icache and dcache refills; CACHE_ARB_RR_EN selects round-robin.
// Latency: grant->arvalid 1 cycle; rlast beat->rend 1 cycle; rend->next arvalid 2 cycles.
// Backpressure: ar* held until arready; rready high for the whole data phase.
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int OFFS_W     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ic_rreq_i,
    input  logic                             ic_uncached_i,
    input  logic [ADDR_W-1:0]                ic_raddr_i,
    output logic                             ic_rend_o,
    output logic `CACHE_LINE_BUS(LINE_WORDS) ic_rdata_o,
    input  logic                             dc_rreq_i,
    input  logic                             dc_uncached_i,
    input  logic [ADDR_W-1:0]                dc_raddr_i,
    output logic                             dc_rend_o,
    output logic `CACHE_LINE_BUS(LINE_WORDS) dc_rdata_o,
    cache_rd_arbiter_if.master               axi
);
    typedef struct packed {
        logic              uncached;
        logic [ADDR_W-1:0] addr;
    } req_t;

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [3:0]        arid_q, arid_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              ic_rend_q, ic_rend_d;
    logic              dc_rend_q, dc_rend_d;

    req_t              sel_req;
    logic              pick_dc;
    owner_e            pick_owner;
    logic              asm_clr;
    logic              asm_we;
    logic `CACHE_LINE_BUS(LINE_WORDS) line;
    logic              unused_axi;

`ifdef CACHE_ARB_RR_EN
    owner_e            last_owner_q, last_owner_d;

    // On contention the requester that did not win last time goes first.
    assign pick_dc = dc_rreq_i && (!ic_rreq_i || (last_owner_q == OWN_IC));
`else
    assign pick_dc = dc_rreq_i;
`endif

    assign pick_owner       = pick_dc ? OWN_DC : OWN_IC;
    assign sel_req.uncached = pick_dc ? dc_uncached_i : ic_uncached_i;
    assign sel_req.addr     = pick_dc ? dc_raddr_i : ic_raddr_i;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ic_rend_d = 1'b0;
        dc_rend_d = 1'b0;
        asm_clr   = 1'b0;
        asm_we    = 1'b0;
`ifdef CACHE_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ic_rreq_i || dc_rreq_i) begin
                    owner_d   = pick_owner;
                    arid_d    = owner_arid(pick_owner);
                    arvalid_d = 1'b1;
                    asm_clr   = 1'b1;
                    state_d   = ST_ADDR;
                    if (sel_req.uncached) begin
                        araddr_d = sel_req.addr;
                        arlen_d  = 8'd0;
                    end else begin
                        araddr_d = {sel_req.addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                        arlen_d  = 8'(LINE_WORDS - 1);
                    end
`ifdef CACHE_ARB_RR_EN
                    last_owner_d = pick_owner;
`endif
                end
            end
            ST_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                asm_we = axi.rvalid && rready_q;
                // rlast alone ends the burst; the beat count never does.
                if (axi.rvalid && axi.rlast) begin
                    rready_d  = 1'b0;
                    state_d   = ST_DONE;
                    ic_rend_d = (owner_q == OWN_IC);
                    dc_rend_d = (owner_q == OWN_DC);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IC;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ic_rend_q <= 1'b0;
            dc_rend_q <= 1'b0;
`ifdef CACHE_ARB_RR_EN
            last_owner_q <= OWN_IC;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ic_rend_q <= ic_rend_d;
            dc_rend_q <= dc_rend_d;
`ifdef CACHE_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    cache_line_assembler #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_asm (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (asm_clr),
        .we_i    (asm_we),
        .wdata_i (axi.rdata),
        .line_o  (line)
    );

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign ic_rend_o  = ic_rend_q;
    assign dc_rend_o  = dc_rend_q;
    assign ic_rdata_o = line;
    assign dc_rdata_o = line;

    // rid and rresp are deliberately not interpreted.
    assign unused_axi = ^{axi.rid, axi.rresp};
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Randomised scoreboard bench: stimulus pushes expected AR/line results, monitors pop and compare.
module tb_cache_rd_arbiter;
    localparam int LW   = 8;
    localparam int AW   = 32;
    localparam int OFFS = 5;
    localparam int LB   = 32 * LW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          ic_rreq = 1'b0, ic_unc = 1'b0, dc_rreq = 1'b0, dc_unc = 1'b0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic          ic_rend, dc_rend;
    logic [LB-1:0] ic_rdata, dc_rdata;

    cache_rd_arbiter_if #(.ADDR_W(AW)) axi_bus ();

    cache_rd_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .OFFS_W(OFFS)) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_rreq_i     (ic_rreq),
        .ic_uncached_i (ic_unc),
        .ic_raddr_i    (ic_addr),
        .ic_rend_o     (ic_rend),
        .ic_rdata_o    (ic_rdata),
        .dc_rreq_i     (dc_rreq),
        .dc_uncached_i (dc_unc),
        .dc_raddr_i    (dc_addr),
        .dc_rend_o     (dc_rend),
        .dc_rdata_o    (dc_rdata),
        .axi           (axi_bus)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; logic [3:0] id; } ar_exp_t;
    typedef struct { bit owner; logic [LB-1:0] line; } rend_exp_t;

    ar_exp_t     exp_ar_q[$];
    rend_exp_t   exp_rend_q[$];
    logic [31:0] beat_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ar_stall_cfg = 0;
    bit gap_en = 1'b0;
    int extra_beats = 0;
    int beats_sent = 0;
    int cyc = 0;
    int last_rend_cyc = 0;
    int ar_rise_cnt = 0;
    int rend_cnt = 0;
    int gap_log[0:1023];
    bit model_last_dc = 1'b0;

    function automatic void chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endfunction

    // Reference model: what the AXI read must look like for a given request.
    function automatic ar_exp_t model_ar(input bit dc, input bit unc, input logic [AW-1:0] a);
        ar_exp_t e;
        logic [AW-1:0] line_mask;
        line_mask = AW'(LW * 4 - 1);
        e.addr = unc ? a : (a & ~line_mask);
        e.len  = unc ? 8'd0 : 8'(LW - 1);
        e.id   = dc ? 4'd1 : 4'd0;
        return e;
    endfunction

    function automatic bit model_first_dc(input bit want_ic, input bit want_dc);
        if (!want_ic) return 1'b1;
        if (!want_dc) return 1'b0;
`ifdef CACHE_ARB_RR_EN
        return !model_last_dc;
`else
        return 1'b1;
`endif
    endfunction

    task automatic serve(input bit dc, input bit unc, input logic [AW-1:0] a);
        bit done;
        done = 1'b0;
        @(negedge clk);
        if (dc) begin dc_unc = unc; dc_addr = a; dc_rreq = 1'b1; end
        else    begin ic_unc = unc; ic_addr = a; ic_rreq = 1'b1; end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((dc && dc_rend) || (!dc && ic_rend)) begin
                done = 1'b1;
                break;
            end
        end
        if (dc) dc_rreq = 1'b0;
        else    ic_rreq = 1'b0;
        chk(dc ? "dc_serve_done" : "ic_serve_done", LB'(done), LB'(1));
    endtask

    task automatic round(input bit want_ic, input bit want_dc,
                         input bit iu, input logic [AW-1:0] ia,
                         input bit du, input logic [AW-1:0] da);
        bit first_dc;
        first_dc = model_first_dc(want_ic, want_dc);
        exp_ar_q.push_back(first_dc ? model_ar(1'b1, du, da) : model_ar(1'b0, iu, ia));
        model_last_dc = first_dc;
        if (want_ic && want_dc) begin
            exp_ar_q.push_back(first_dc ? model_ar(1'b0, iu, ia) : model_ar(1'b1, du, da));
            model_last_dc = !first_dc;
        end
        fork
            begin if (want_ic) serve(1'b0, iu, ia); end
            begin if (want_dc) serve(1'b1, du, da); end
        join
        @(negedge clk);
    endtask

    // AXI slave: stalls AR by ar_stall_cfg cycles, streams beats, builds the expected line.
    initial begin : responder
        int          stall_left;
        bit          ar_pend, in_burst, ar_seen, owner;
        int          beats_left, beat_idx;
        logic [31:0] d;
        logic [LB-1:0] mline;
        ar_exp_t     e;
        stall_left = 0; ar_pend = 0; in_burst = 0; ar_seen = 0; owner = 0;
        beats_left = 0; beat_idx = 0; mline = '0;
        axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
        axi_bus.rdata = '0; axi_bus.rid = '0; axi_bus.rresp = '0;
        forever begin
            @(negedge clk);
            axi_bus.rvalid = 1'b0;
            axi_bus.rlast  = 1'b0;
            if (rst) begin
                axi_bus.arready = 1'b0;
                ar_pend = 0; in_burst = 0; ar_seen = 0;
                continue;
            end
            if (ar_pend) begin
                ar_pend = 0; ar_seen = 0; in_burst = 1;
                axi_bus.arready = 1'b0;
                beat_idx = 0; mline = '0;
            end
            if (in_burst) begin
                if (axi_bus.rready && !(gap_en && $urandom_range(0, 2) == 0)) begin
                    d = (beat_q.size() > 0) ? beat_q.pop_front() : $urandom;
                    axi_bus.rvalid = 1'b1;
                    axi_bus.rdata  = d;
                    axi_bus.rid    = {3'b0, owner};
                    axi_bus.rlast  = (beats_left == 1);
                    mline[(beat_idx % LW) * 32 +: 32] = d;
                    beat_idx++;
                    beats_left--;
                    beats_sent++;
                    if (beats_left == 0) begin
                        in_burst = 0;
                        exp_rend_q.push_back('{owner: owner, line: mline});
                    end
                end
            end else if (axi_bus.arvalid) begin
                if (!ar_seen) begin ar_seen = 1; stall_left = ar_stall_cfg; end
                if (stall_left > 0) begin
                    stall_left--;
                    axi_bus.arready = 1'b0;
                end else begin
                    axi_bus.arready = 1'b1;
                    ar_pend = 1;
                    if (exp_ar_q.size() == 0) begin
                        fail_now("unexpected_ar");
                        owner = axi_bus.arid[0];
                        beats_left = int'(axi_bus.arlen) + 1;
                    end else begin
                        e = exp_ar_q.pop_front();
                        chk("araddr", LB'(axi_bus.araddr), LB'(e.addr));
                        chk("arlen", LB'(axi_bus.arlen), LB'(e.len));
                        chk("arid", LB'(axi_bus.arid), LB'(e.id));
                        chk("arsize", LB'(axi_bus.arsize), LB'(3'b010));
                        chk("arburst", LB'(axi_bus.arburst), LB'(2'b01));
                        owner = e.id[0];
                        beats_left = int'(e.len) + 1 + extra_beats;
                    end
                end
            end
        end
    end

    // Output monitor: AR stability, rend pulses against the scoreboard, rend->arvalid gaps.
    initial begin : monitor
        logic          prev_arvalid, prev_rend;
        logic [AW-1:0] p_addr;
        logic [7:0]    p_len;
        logic [3:0]    p_id;
        rend_exp_t     r;
        prev_arvalid = 0; prev_rend = 0; p_addr = '0; p_len = '0; p_id = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_arvalid = 0;
                prev_rend = 0;
                continue;
            end
            if (axi_bus.arvalid && !prev_arvalid) begin
                if (ar_rise_cnt < 1024) gap_log[ar_rise_cnt] = cyc - last_rend_cyc;
                ar_rise_cnt++;
            end
            if (axi_bus.arvalid && prev_arvalid) begin
                chk("ar_hold_addr", LB'(axi_bus.araddr), LB'(p_addr));
                chk("ar_hold_len", LB'(axi_bus.arlen), LB'(p_len));
                chk("ar_hold_id", LB'(axi_bus.arid), LB'(p_id));
            end
            if (prev_rend) chk("rend_width", LB'(ic_rend | dc_rend), LB'(0));
            if (ic_rend || dc_rend) begin
                chk("rend_onehot", LB'(ic_rend & dc_rend), LB'(0));
                if (exp_rend_q.size() == 0) fail_now("unexpected_rend");
                else begin
                    r = exp_rend_q.pop_front();
                    chk("rend_owner_dc", LB'(dc_rend), LB'(r.owner));
                    chk("ic_rdata", ic_rdata, r.line);
                    chk("dc_rdata", dc_rdata, r.line);
                end
                rend_cnt++;
                last_rend_cyc = cyc;
            end
            prev_arvalid = axi_bus.arvalid;
            prev_rend    = ic_rend | dc_rend;
            p_addr = axi_bus.araddr;
            p_len  = axi_bus.arlen;
            p_id   = axi_bus.arid;
        end
    end

    initial begin : stimulus
        int k, rc, base, r;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", LB'(axi_bus.arvalid), LB'(0));
        chk("rst_rready", LB'(axi_bus.rready), LB'(0));
        chk("rst_ic_rend", LB'(ic_rend), LB'(0));
        chk("rst_dc_rend", LB'(dc_rend), LB'(0));
        chk("rst_araddr", LB'(axi_bus.araddr), LB'(0));
        chk("rst_arlen", LB'(axi_bus.arlen), LB'(0));
        chk("rst_arsize", LB'(axi_bus.arsize), LB'(3'b010));
        chk("rst_arburst", LB'(axi_bus.arburst), LB'(2'b01));
        chk("rst_line", ic_rdata, LB'(0));
        rst = 1'b0;
        @(negedge clk);

        // Cached dcache miss with known beat data.
        for (int i = 0; i < LW; i++) beat_q.push_back(32'hA0 + 32'(i));
        round(1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h1FC0_0014);

        // Uncached icache single-word read.
        beat_q.push_back(32'h2402_0001);
        round(1'b1, 1'b0, 1'b1, 32'hBFC0_0104, 1'b0, '0);

        // Two contention rounds; loser's arvalid follows winner's rend by 2 cycles.
        for (int n = 0; n < 2; n++) begin
            k = ar_rise_cnt;
            round(1'b1, 1'b1, 1'b0, $urandom, 1'b0, $urandom);
            chk("contend_ar_count", LB'(ar_rise_cnt - k), LB'(2));
            if (k + 1 < 1024) chk("b2b_gap", LB'(gap_log[k + 1]), LB'(2));
        end

        // Backpressure on AR and gaps on R.
        ar_stall_cfg = 5;
        gap_en = 1'b1;
        rc = rend_cnt;
        round(1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h0000_3A7C);
        chk("bp_rend_count", LB'(rend_cnt - rc), LB'(1));
        ar_stall_cfg = 0;
        gap_en = 1'b0;

        // Overlong burst: words past the end wrap onto word 0.
        extra_beats = 3;
        round(1'b1, 1'b0, 1'b0, 32'h0040_0088, 1'b0, '0);
        extra_beats = 0;

        // Reset after the third beat of a cached read.
        beat_q.delete();
        exp_ar_q.push_back(model_ar(1'b1, 1'b0, 32'h8000_1234));
        base = beats_sent;
        @(negedge clk);
        dc_unc = 1'b0; dc_addr = 32'h8000_1234; dc_rreq = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (beats_sent - base >= 3) begin seen = 1'b1; break; end
        end
        chk("rst_mid_reached_beat3", LB'(seen), LB'(1));
        @(negedge clk);
        rst = 1'b1;
        dc_rreq = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_arvalid", LB'(axi_bus.arvalid), LB'(0));
        chk("rst_mid_rready", LB'(axi_bus.rready), LB'(0));
        chk("rst_mid_rend", LB'(ic_rend | dc_rend), LB'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_ar_q.delete();
        exp_rend_q.delete();
        beat_q.delete();
        model_last_dc = 1'b0;
        round(1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h0000_2040);

        // Randomised rounds.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 2);
            ar_stall_cfg = $urandom_range(0, 3);
            gap_en = 1'($urandom_range(0, 1));
            round(r != 1, r != 0, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), $urandom);
        end

        repeat (5) @(negedge clk);
        chk("ar_queue_drained", LB'(exp_ar_q.size()), LB'(0));
        chk("rend_queue_drained", LB'(exp_rend_q.size()), LB'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
